// File: rtl/pulse_width_meter.sv
// pulse_width_meter: measures the high and low phases of a synchronized signal
// in clk2 cycles, using the single-cycle edge pulses from the upstream edge
// detector. Completed phases are queued in a small FIFO and presented on a
// valid/ready interface. Sticky flags report dropped records and bad edges.
module pulse_width_meter #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk2,
    input  logic         rstn,
    input  logic         sig2_pos,
    input  logic         sig2_neg,
    input  logic         clr,
    input  logic         m_ready,
    output logic         m_valid,
    output logic         m_level,
    output logic [W-1:0] m_width,
    output logic         m_sat,
    output logic         ovf,
    output logic         err
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = W + 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam logic [W-1:0]  CNT_MAX = '1;
    localparam logic [W-1:0]  CNT_ONE = W'(1);
    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

    logic [1:0]    state, state_nxt;
    logic [W-1:0]  cnt, cnt_nxt, cnt_step;
    logic          sat, sat_nxt, sat_step;
    logic          push, proto_err;
    logic [RW-1:0] push_rec;

    logic [RW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, empty, pop, wr_en, drop;
    logic [RW-1:0] head;

    // A running phase holds at the top count and remembers that it clipped.
    assign cnt_step = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    assign sat_step = sat | (cnt == CNT_MAX);

    // The record describes the phase that the current edge is closing.
    assign push_rec = {(state == ST_HIGH), cnt, sat};

    // Phase tracker: decides the next level, count and whether to emit a record.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sat_nxt   = sat;
        push      = 1'b0;
        proto_err = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sig2_pos && sig2_neg) begin
                    proto_err = 1'b1;
                end else if (sig2_pos) begin
                    state_nxt = ST_HIGH;
                    cnt_nxt   = CNT_ONE;
                    sat_nxt   = 1'b0;
                end else if (sig2_neg) begin
                    state_nxt = ST_LOW;
                    cnt_nxt   = CNT_ONE;
                    sat_nxt   = 1'b0;
                end
            end
            ST_HIGH: begin
                if (sig2_pos && sig2_neg) begin
                    proto_err = 1'b1;
                    cnt_nxt   = cnt_step;
                    sat_nxt   = sat_step;
                end else if (sig2_pos) begin
                    proto_err = 1'b1;
                    cnt_nxt   = CNT_ONE;
                    sat_nxt   = 1'b0;
                end else if (sig2_neg) begin
                    push      = 1'b1;
                    state_nxt = ST_LOW;
                    cnt_nxt   = CNT_ONE;
                    sat_nxt   = 1'b0;
                end else begin
                    cnt_nxt   = cnt_step;
                    sat_nxt   = sat_step;
                end
            end
            ST_LOW: begin
                if (sig2_pos && sig2_neg) begin
                    proto_err = 1'b1;
                    cnt_nxt   = cnt_step;
                    sat_nxt   = sat_step;
                end else if (sig2_neg) begin
                    proto_err = 1'b1;
                    cnt_nxt   = CNT_ONE;
                    sat_nxt   = 1'b0;
                end else if (sig2_pos) begin
                    push      = 1'b1;
                    state_nxt = ST_HIGH;
                    cnt_nxt   = CNT_ONE;
                    sat_nxt   = 1'b0;
                end else begin
                    cnt_nxt   = cnt_step;
                    sat_nxt   = sat_step;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
                sat_nxt   = 1'b0;
            end
        endcase
    end

    // Phase tracker registers; reset forgets any partially measured phase.
    always_ff @(posedge clk2 or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            cnt   <= '0;
            sat   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            sat   <= sat_nxt;
        end
    end

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign pop   = !empty && m_ready;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    // Record storage; a write into a full FIFO reuses the slot being popped.
    always_ff @(posedge clk2) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= push_rec;
        end
    end

    // FIFO pointers with an extra wrap bit to tell full from empty.
    always_ff @(posedge clk2 or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Sticky flags: a new event in the same cycle as clr keeps the flag set.
    always_ff @(posedge clk2 or negedge rstn) begin
        if (!rstn) begin
            ovf <= 1'b0;
            err <= 1'b0;
        end else begin
            ovf <= drop | (ovf & ~clr);
            err <= proto_err | (err & ~clr);
        end
    end

    // Head fields are forced to zero when empty so unwritten slots never leak out.
    assign head    = mem[rd_ptr[AW-1:0]];
    assign m_valid = !empty;
    assign m_level = empty ? 1'b0 : head[RW-1];
    assign m_width = empty ? '0 : head[W:1];
    assign m_sat   = empty ? 1'b0 : head[0];

endmodule
